btn_debounce_repeat: RTL and testbench



---
 rtl/btn_debounce_repeat.sv | 136 +++++++++++++
 tb/tb_btn_debounce_repeat.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_repeat.sv
// Per-button synchronizer, tick-sampled debouncer and auto-repeat generator.
// All buttons share one sample tick; pulse outputs are registered.
module btn_debounce_repeat #(
  parameter int pBtnWidth      = 6,
  parameter int pMonitorTiming = 500000,
  parameter int pStableCount   = 4,
  parameter int pRepeatDelay   = 60,
  parameter int pRepeatRate    = 20
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [pBtnWidth-1:0] iBtn,
  output logic [pBtnWidth-1:0] oBtn,
  output logic [pBtnWidth-1:0] oBtnPress,
  output logic [pBtnWidth-1:0] oBtnRelease,
  output logic [pBtnWidth-1:0] oBtnRepeat,
  output logic                 oAnyPress
);

  localparam int TW   = (pMonitorTiming > 1) ? $clog2(pMonitorTiming) : 1;
  localparam int RMAX = (pRepeatDelay > pRepeatRate) ? pRepeatDelay
                                                     : pRepeatRate;
  localparam int RW   = $clog2(RMAX) + 1;

  typedef enum logic {PH_DELAY = 1'b0, PH_RATE = 1'b1} phase_e;
  typedef logic [pStableCount-1:0] hist_t;
  typedef logic [RW-1:0]           rep_t;

  logic [pBtnWidth-1:0] sync1_q, sync2_q;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 tick;

  hist_t  hist_q [pBtnWidth];
  hist_t  hist_d [pBtnWidth];
  hist_t  hnext  [pBtnWidth];
  rep_t   rep_q  [pBtnWidth];
  rep_t   rep_d  [pBtnWidth];
  rep_t   repn   [pBtnWidth];
  phase_e ph_q   [pBtnWidth];
  phase_e ph_d   [pBtnWidth];

  logic [pBtnWidth-1:0] btn_q, btn_d;
  logic [pBtnWidth-1:0] prs_q, prs_d;
  logic [pBtnWidth-1:0] rel_q, rel_d;
  logic [pBtnWidth-1:0] rpt_q, rpt_d;
  logic                 any_q, any_d;

  assign tick   = (tcnt_q == TW'(pMonitorTiming - 1));
  assign tcnt_d = tick ? '0 : tcnt_q + TW'(1);

  for (genvar g = 0; g < pBtnWidth; g++) begin : g_nx
    assign hnext[g] = {hist_q[g][pStableCount-2:0], sync2_q[g]};
    assign repn[g]  = rep_q[g] + rep_t'(1);
  end

  // Tick-time decision per button; pulses default low every cycle
  always_comb begin
    btn_d = btn_q;
    prs_d = '0;
    rel_d = '0;
    rpt_d = '0;
    for (int i = 0; i < pBtnWidth; i++) begin
      hist_d[i] = hist_q[i];
      rep_d[i]  = rep_q[i];
      ph_d[i]   = ph_q[i];
      if (tick) begin
        hist_d[i] = hnext[i];
        if ((&hnext[i]) && !btn_q[i]) begin
          btn_d[i] = 1'b1;
          prs_d[i] = 1'b1;
          rpt_d[i] = 1'b1;
          rep_d[i] = '0;
          ph_d[i]  = PH_DELAY;
        end else if (!(|hnext[i]) && btn_q[i]) begin
          btn_d[i] = 1'b0;
          rel_d[i] = 1'b1;
          rep_d[i] = '0;
          ph_d[i]  = PH_DELAY;
        end else if (btn_q[i]) begin
          if (ph_q[i] == PH_DELAY &&
              repn[i] == rep_t'(pRepeatDelay)) begin
            rpt_d[i] = 1'b1;
            rep_d[i] = '0;
            ph_d[i]  = PH_RATE;
          end else if (ph_q[i] == PH_RATE &&
                       repn[i] == rep_t'(pRepeatRate)) begin
            rpt_d[i] = 1'b1;
            rep_d[i] = '0;
          end else begin
            rep_d[i] = repn[i];
          end
        end
      end
    end
    any_d = |prs_d;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      tcnt_q  <= '0;
      btn_q   <= '0;
      prs_q   <= '0;
      rel_q   <= '0;
      rpt_q   <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < pBtnWidth; i++) begin
        hist_q[i] <= '0;
        rep_q[i]  <= '0;
        ph_q[i]   <= PH_DELAY;
      end
    end else begin
      sync1_q <= iBtn;
      sync2_q <= sync1_q;
      tcnt_q  <= tcnt_d;
      btn_q   <= btn_d;
      prs_q   <= prs_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      any_q   <= any_d;
      for (int i = 0; i < pBtnWidth; i++) begin
        hist_q[i] <= hist_d[i];
        rep_q[i]  <= rep_d[i];
        ph_q[i]   <= ph_d[i];
      end
    end
  end

  assign oBtn        = btn_q;
  assign oBtnPress   = prs_q;
  assign oBtnRelease = rel_q;
  assign oBtnRepeat  = rpt_q;
  assign oAnyPress   = any_q;

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Bench for btn_debounce_repeat: directed timing scenarios plus
// randomized button activity against a tick-level behavioural model.
module tb_btn_debounce_repeat;

  localparam int W  = 6;
  localparam int MT = 4;
  localparam int S  = 3;
  localparam int D  = 5;
  localparam int R  = 2;

  logic         clk = 1'b0;
  logic         iRST = 1'b1;
  logic [W-1:0] iBtn = '0;
  logic [W-1:0] oBtn, oBtnPress, oBtnRelease, oBtnRepeat;
  logic         oAnyPress;

  int checks = 0;
  int errors = 0;

  btn_debounce_repeat #(
    .pBtnWidth(W), .pMonitorTiming(MT), .pStableCount(S),
    .pRepeatDelay(D), .pRepeatRate(R)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iBtn(iBtn),
    .oBtn(oBtn), .oBtnPress(oBtnPress), .oBtnRelease(oBtnRelease),
    .oBtnRepeat(oBtnRepeat), .oAnyPress(oAnyPress)
  );

  always #5 clk = ~clk;

  // Model state: sample runs per button and press tick numbers
  int           m_c, m_tick;
  logic [W-1:0] m_s1, m_s2;
  logic [W-1:0] m_btn, m_prs, m_rel, m_rpt;
  logic         m_any;
  logic         runval [W];
  int           run    [W];
  int           tpress [W];

  // Per-cycle log of DUT outputs for directed checks
  int           abs_n;
  logic [W-1:0] lbtn [0:127];
  logic [W-1:0] lprs [0:127];
  logic [W-1:0] lrel [0:127];
  logic [W-1:0] lrpt [0:127];
  logic         lany [0:127];

  logic [W-1:0] b;
  int           cnt;
  int           dur [W];
  logic [W-1:0] cur;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [W-1:0] bi, input logic r);
    int k;
    if (r) begin
      m_c = 0; m_tick = 0; m_s1 = '0; m_s2 = '0;
      m_btn = '0; m_prs = '0; m_rel = '0; m_rpt = '0;
      for (int i = 0; i < W; i++) begin
        runval[i] = 1'b0; run[i] = S; tpress[i] = 0;
      end
    end else begin
      m_prs = '0; m_rel = '0; m_rpt = '0;
      if (m_c % MT == MT - 1) begin
        m_tick++;
        for (int i = 0; i < W; i++) begin
          if (m_s2[i] == runval[i]) run[i]++;
          else begin runval[i] = m_s2[i]; run[i] = 1; end
          if (runval[i] && run[i] >= S && !m_btn[i]) begin
            m_btn[i] = 1'b1; m_prs[i] = 1'b1; m_rpt[i] = 1'b1;
            tpress[i] = m_tick;
          end else if (!runval[i] && run[i] >= S && m_btn[i]) begin
            m_btn[i] = 1'b0; m_rel[i] = 1'b1;
          end else if (m_btn[i]) begin
            k = m_tick - tpress[i];
            if (k == D || (k > D && (k - D) % R == 0)) m_rpt[i] = 1'b1;
          end
        end
      end
      m_s2 = m_s1; m_s1 = bi; m_c++;
    end
    m_any = |m_prs;
  endtask

  task automatic cyc(input logic [W-1:0] bi, input logic r);
    iBtn = bi;
    iRST = r;
    @(posedge clk);
    #1;
    model_edge(bi, r);
    abs_n++;
    if (abs_n < 128) begin
      lbtn[abs_n] = oBtn; lprs[abs_n] = oBtnPress;
      lrel[abs_n] = oBtnRelease; lrpt[abs_n] = oBtnRepeat;
      lany[abs_n] = oAnyPress;
    end
    chk("btn", 32'(oBtn), 32'(m_btn));
    chk("press", 32'(oBtnPress), 32'(m_prs));
    chk("release", 32'(oBtnRelease), 32'(m_rel));
    chk("repeat", 32'(oBtnRepeat), 32'(m_rpt));
    chk("any", 32'(oAnyPress), 32'(m_any));
  endtask

  initial begin
    abs_n = 0;
    repeat (3) cyc('0, 1'b1);
    chk("reset_btn", 32'(oBtn), 32'd0);
    chk("reset_pulses", 32'({oBtnPress, oBtnRelease, oBtnRepeat, oAnyPress}),
        32'd0);

    // Press, repeat, release on bit0; glitch on bit2; bit5 held throughout
    abs_n = 0;
    for (int c = 0; c < 80; c++) begin
      b = '0;
      b[0] = (c < 50);
      b[2] = (c <= 5);
      b[5] = 1'b1;
      cyc(b, 1'b0);
    end
    chk("pre_press", 32'(lbtn[11]), 32'd0);
    chk("press_lvl", 32'(lbtn[12]), 32'b100001);
    chk("press_pulse", 32'(lprs[12]), 32'b100001);
    chk("press_rpt", 32'(lrpt[12]), 32'b100001);
    chk("press_any", 32'(lany[12]), 32'd1);
    cnt = 0;
    for (int n = 1; n < 80; n++) begin
      if (lany[n]) cnt++;
      chk("b0_rpt", 32'(lrpt[n][0]),
          32'(n inside {12, 32, 40, 48, 56}));
      chk("b5_rpt", 32'(lrpt[n][5]),
          32'(n inside {12, 32, 40, 48, 56, 64, 72}));
      chk("b0_rel", 32'(lrel[n]), (n == 64) ? 32'd1 : 32'd0);
      chk("b0_lvl", 32'(lbtn[n][0]), 32'(n >= 12 && n < 64));
      chk("b2_quiet", 32'({lbtn[n][2], lprs[n][2], lrpt[n][2]}), 32'd0);
      chk("no_repress", 32'(lprs[n]), (n == 12) ? 32'b100001 : 32'd0);
    end
    chk("any_once", 32'(cnt), 32'd1);

    // Reset while bit1 is held
    cyc('0, 1'b1);
    cyc('0, 1'b1);
    abs_n = 0;
    for (int c = 0; c < 45; c++) cyc(6'b000010, (c == 20));
    chk("mid_pre", 32'(lbtn[12]), 32'b000010);
    chk("mid_clear", 32'({lbtn[21], lprs[21], lrel[21], lrpt[21], lany[21]}),
        32'd0);
    chk("mid_wait", 32'(lbtn[32]), 32'd0);
    chk("mid_relvl", 32'(lbtn[33]), 32'b000010);
    chk("mid_repress", 32'(lprs[33]), 32'b000010);

    // Randomized hold/glitch activity with occasional resets
    for (int i = 0; i < W; i++) dur[i] = $urandom_range(1, 60);
    cur = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < W; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          cur[i] = ~cur[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8)
                                                : $urandom_range(8, 90);
        end
      end
      cyc(cur, ($urandom_range(0, 799) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
